// File: rtl/mlp_ctrl_pkg.sv
// rtl/mlp_ctrl_pkg.sv - shared constants, control entry type and parity helper for the MLP control path
// Contents:
//   DEF_ADDR_W  default output-neuron address width
//   MAX_DEPTH   largest supported control pipeline depth
//   ctrl_entry  {valid, reset_acc, addr} record at the default address width
//   even_parity parity bit that makes {reset_acc, addr, parity} have even weight
package mlp_ctrl_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int MAX_DEPTH  = 16;

  typedef struct packed {
    logic                  valid;
    logic                  reset_acc;
    logic [DEF_ADDR_W-1:0] addr;
  } ctrl_entry;

  // addr is zero-extended by the caller; zero bits do not change the parity.
  function automatic logic even_parity(input logic reset_acc, input logic [31:0] addr);
    return reset_acc ^ (^addr);
  endfunction

endpackage

// File: rtl/mac_ctrl_stage.sv
// rtl/mac_ctrl_stage.sv - one register stage of the MAC control delay line
// Optional feature macro: MAC_CTRL_PIPE_PARITY_EN (adds d_par/q_par storage)
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   clear               synchronous clear of the whole stage (wins over hold)
//   hold                keep current contents; otherwise the stage loads d_*
//   d_valid/d_reset_acc/d_addr[/d_par]  next contents
//   q_valid/q_reset_acc/q_addr[/q_par]  registered contents
module mac_ctrl_stage
  import mlp_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              hold,
  input  logic              d_valid,
  input  logic              d_reset_acc,
  input  logic [ADDR_W-1:0] d_addr,
`ifdef MAC_CTRL_PIPE_PARITY_EN
  input  logic              d_par,
  output logic              q_par,
`endif
  output logic              q_valid,
  output logic              q_reset_acc,
  output logic [ADDR_W-1:0] q_addr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid     <= 1'b0;
      q_reset_acc <= 1'b0;
      q_addr      <= '0;
    end else if (clear) begin
      q_valid     <= 1'b0;
      q_reset_acc <= 1'b0;
      q_addr      <= '0;
    end else if (!hold) begin
      q_valid     <= d_valid;
      q_reset_acc <= d_reset_acc;
      q_addr      <= d_addr;
    end
  end

`ifdef MAC_CTRL_PIPE_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_par <= 1'b0;
    end else if (clear) begin
      q_par <= 1'b0;
    end else if (!hold) begin
      q_par <= d_par;
    end
  end
`endif

endmodule

// File: rtl/mac_ctrl_pipe.sv
// rtl/mac_ctrl_pipe.sv - DEPTH-stage delay line for MAC reset pulse and neuron address
// Optional feature macro: MAC_CTRL_PIPE_PARITY_EN (per-stage even parity, sticky parity_err)
// Ports:
//   clk, reset                         clock, asynchronous active-low reset
//   flush                              synchronous clear of all stages, count and parity_err
//   stall                              hold every stage and the count; input not captured
//   in_valid/in_reset_acc/in_addr      entry offered to stage 0
//   out_valid/out_reset_acc/out_addr   last-stage contents
//   in_flight                          number of valid stages
//   parity_err                         sticky parity error (0 when parity is not built)
module mac_ctrl_pipe
  import mlp_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              stall,
  input  logic              in_valid,
  input  logic              in_reset_acc,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic              out_reset_acc,
  output logic [ADDR_W-1:0] out_addr,
  output logic [CNT_W-1:0]  in_flight,
  output logic              parity_err
);

  logic              d_valid     [DEPTH];
  logic              d_reset_acc [DEPTH];
  logic [ADDR_W-1:0] d_addr      [DEPTH];
  logic              q_valid     [DEPTH];
  logic              q_reset_acc [DEPTH];
  logic [ADDR_W-1:0] q_addr      [DEPTH];
`ifdef MAC_CTRL_PIPE_PARITY_EN
  logic              d_par       [DEPTH];
  logic              q_par       [DEPTH];
`endif

  // Invalid entries are zeroed at capture so a stray reset_acc/addr can never
  // travel down the line.
  always_comb begin
    d_valid[0]     = in_valid;
    d_reset_acc[0] = in_valid & in_reset_acc;
    d_addr[0]      = in_valid ? in_addr : '0;
    for (int k = 1; k < DEPTH; k++) begin
      d_valid[k]     = q_valid[k-1];
      d_reset_acc[k] = q_reset_acc[k-1];
      d_addr[k]      = q_addr[k-1];
    end
  end

`ifdef MAC_CTRL_PIPE_PARITY_EN
  always_comb begin
    d_par[0] = even_parity(d_reset_acc[0], 32'(d_addr[0]));
    for (int k = 1; k < DEPTH; k++) begin
      d_par[k] = q_par[k-1];
    end
  end
`endif

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    mac_ctrl_stage #(
      .ADDR_W (ADDR_W)
    ) u_stage (
      .clk         (clk),
      .reset       (reset),
      .clear       (flush),
      .hold        (stall),
      .d_valid     (d_valid[k]),
      .d_reset_acc (d_reset_acc[k]),
      .d_addr      (d_addr[k]),
`ifdef MAC_CTRL_PIPE_PARITY_EN
      .d_par       (d_par[k]),
      .q_par       (q_par[k]),
`endif
      .q_valid     (q_valid[k]),
      .q_reset_acc (q_reset_acc[k]),
      .q_addr      (q_addr[k])
    );
  end

  assign out_valid     = q_valid[DEPTH-1];
  assign out_reset_acc = q_reset_acc[DEPTH-1];
  assign out_addr      = q_addr[DEPTH-1];

  // The entry leaving the last stage and the one entering stage 0 cancel out,
  // so the count tracks the number of valid stages without ever exceeding DEPTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_flight <= '0;
    end else if (flush) begin
      in_flight <= '0;
    end else if (!stall) begin
      in_flight <= in_flight + CNT_W'(in_valid) - CNT_W'(out_valid);
    end
  end

`ifdef MAC_CTRL_PIPE_PARITY_EN
  // Checked whenever the last stage is valid, stalled or not.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else if (flush) begin
      parity_err <= 1'b0;
    end else if (out_valid &&
                 (even_parity(out_reset_acc, 32'(out_addr)) != q_par[DEPTH-1])) begin
      parity_err <= 1'b1;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_mac_ctrl_pipe.sv
// tb/tb_mac_ctrl_pipe.sv - self-checking bench for mac_ctrl_pipe at DEPTH 1, 3 and 4
module tb_mac_ctrl_pipe;
  import mlp_ctrl_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          flush;
  logic          stall;
  logic          in_valid;
  logic          in_reset_acc;
  logic [AW-1:0] in_addr;

  logic          ov  [3];
  logic          orr [3];
  logic [AW-1:0] oa  [3];
  logic          pe  [3];
  logic [0:0]    if1;
  logic [1:0]    if3;
  logic [2:0]    if4;

  mac_ctrl_pipe #(.ADDR_W(AW), .DEPTH(1)) u_d1 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_reset_acc(in_reset_acc), .in_addr(in_addr),
    .out_valid(ov[0]), .out_reset_acc(orr[0]), .out_addr(oa[0]),
    .in_flight(if1), .parity_err(pe[0])
  );

  mac_ctrl_pipe #(.ADDR_W(AW), .DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_reset_acc(in_reset_acc), .in_addr(in_addr),
    .out_valid(ov[1]), .out_reset_acc(orr[1]), .out_addr(oa[1]),
    .in_flight(if3), .parity_err(pe[1])
  );

  mac_ctrl_pipe #(.ADDR_W(AW), .DEPTH(4)) u_d4 (
    .clk(clk), .reset(reset), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_reset_acc(in_reset_acc), .in_addr(in_addr),
    .out_valid(ov[2]), .out_reset_acc(orr[2]), .out_addr(oa[2]),
    .in_flight(if4), .parity_err(pe[2])
  );

  int tests = 0;
  int fails = 0;
  int dep [3] = '{1, 3, 4};

  // Reference: per instance, a history of the entries offered on the last
  // MAX_DEPTH shift cycles (index 0 = newest); an instance of depth D shows
  // entry D-1 on its outputs.
  ctrl_entry hist [3][MAX_DEPTH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] act_if(input int i);
    case (i)
      0:       return 32'(if1);
      1:       return 32'(if3);
      default: return 32'(if4);
    endcase
  endfunction

  function automatic int model_count(input int i);
    int n = 0;
    for (int k = 0; k < dep[i]; k++) n += int'(hist[i][k].valid);
    return n;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++)
      for (int k = 0; k < MAX_DEPTH; k++) hist[i][k] = '0;
  endtask

  task automatic model_edge();
    ctrl_entry e;
    if (flush) begin
      model_clear();
    end else if (!stall) begin
      e = '0;
      if (in_valid) begin
        e.valid     = 1'b1;
        e.reset_acc = in_reset_acc;
        e.addr      = in_addr;
      end
      for (int i = 0; i < 3; i++) begin
        for (int k = MAX_DEPTH - 1; k > 0; k--) hist[i][k] = hist[i][k-1];
        hist[i][0] = e;
      end
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < 3; i++) begin
      ctrl_entry o;
      o = hist[i][dep[i]-1];
      chk($sformatf("%s d%0d out_valid", tag, dep[i]), 32'(ov[i]), 32'(o.valid));
      chk($sformatf("%s d%0d out_reset_acc", tag, dep[i]), 32'(orr[i]), 32'(o.reset_acc));
      chk($sformatf("%s d%0d out_addr", tag, dep[i]), 32'(oa[i]), 32'(o.addr));
      chk($sformatf("%s d%0d in_flight", tag, dep[i]), act_if(i), 32'(model_count(i)));
      chk($sformatf("%s d%0d parity_err", tag, dep[i]), 32'(pe[i]), 32'd0);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive(input logic fl, input logic st, input logic v, input logic r,
                       input logic [AW-1:0] a);
    flush        = fl;
    stall        = st;
    in_valid     = v;
    in_reset_acc = r;
    in_addr      = a;
  endtask

  // Directed vectors with hand-derived DEPTH=4 expectations (applied to all
  // three instances; the model covers depths 1 and 3).
  typedef struct {
    logic          fl, st, v, r;
    logic [AW-1:0] a;
    logic          ev, er;
    logic [AW-1:0] ea;
    logic [2:0]    ei;
  } vec_t;

  vec_t tbl [29];

  initial begin
    tbl[0]  = '{0,0,1,1,12'h005, 0,0,12'h000,3'd1};
    tbl[1]  = '{0,0,1,0,12'h006, 0,0,12'h000,3'd2};
    tbl[2]  = '{0,0,1,0,12'h007, 0,0,12'h000,3'd3};
    tbl[3]  = '{0,0,0,1,12'hFFF, 1,1,12'h005,3'd3};
    tbl[4]  = '{0,0,0,0,12'h000, 1,0,12'h006,3'd2};
    tbl[5]  = '{0,0,0,0,12'h000, 1,0,12'h007,3'd1};
    tbl[6]  = '{0,0,0,0,12'h000, 0,0,12'h000,3'd0};
    tbl[7]  = '{0,0,1,0,12'hABC, 0,0,12'h000,3'd1};
    tbl[8]  = '{0,1,1,0,12'h111, 0,0,12'h000,3'd1};
    tbl[9]  = '{0,1,1,0,12'h111, 0,0,12'h000,3'd1};
    tbl[10] = '{0,0,0,0,12'h000, 0,0,12'h000,3'd1};
    tbl[11] = '{0,0,0,0,12'h000, 0,0,12'h000,3'd1};
    tbl[12] = '{0,0,0,0,12'h000, 1,0,12'hABC,3'd1};
    tbl[13] = '{0,0,0,0,12'h000, 0,0,12'h000,3'd0};
    tbl[14] = '{0,0,1,0,12'h001, 0,0,12'h000,3'd1};
    tbl[15] = '{0,0,1,0,12'h002, 0,0,12'h000,3'd2};
    tbl[16] = '{0,0,1,0,12'h003, 0,0,12'h000,3'd3};
    tbl[17] = '{1,1,1,1,12'h004, 0,0,12'h000,3'd0};
    tbl[18] = '{0,0,0,0,12'h000, 0,0,12'h000,3'd0};
    tbl[19] = '{0,0,0,0,12'h000, 0,0,12'h000,3'd0};
    tbl[20] = '{0,0,0,0,12'h000, 0,0,12'h000,3'd0};
    tbl[21] = '{0,0,0,0,12'h000, 0,0,12'h000,3'd0};
    tbl[22] = '{0,0,1,1,12'h020, 0,0,12'h000,3'd1};
    tbl[23] = '{0,0,1,0,12'h021, 0,0,12'h000,3'd2};
    tbl[24] = '{0,0,1,0,12'h022, 0,0,12'h000,3'd3};
    tbl[25] = '{0,0,1,0,12'h023, 1,1,12'h020,3'd4};
    tbl[26] = '{0,0,1,0,12'h024, 1,0,12'h021,3'd4};
    tbl[27] = '{1,0,1,0,12'h025, 0,0,12'h000,3'd0};
    tbl[28] = '{0,0,0,0,12'h000, 0,0,12'h000,3'd0};

    model_clear();
    reset = 1'b0;
    drive(0, 0, 0, 0, '0);
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset = 1'b1;

    for (int n = 0; n < 29; n++) begin
      drive(tbl[n].fl, tbl[n].st, tbl[n].v, tbl[n].r, tbl[n].a);
      step($sformatf("vec%0d", n));
      chk($sformatf("vec%0d tbl out_valid", n), 32'(ov[2]), 32'(tbl[n].ev));
      chk($sformatf("vec%0d tbl out_reset_acc", n), 32'(orr[2]), 32'(tbl[n].er));
      chk($sformatf("vec%0d tbl out_addr", n), 32'(oa[2]), 32'(tbl[n].ea));
      chk($sformatf("vec%0d tbl in_flight", n), 32'(if4), 32'(tbl[n].ei));
    end

    // Asynchronous reset while the DEPTH=4 line is full and presenting output.
    for (int n = 0; n < 4; n++) begin
      drive(0, 0, 1, 1, AW'(12'h030 + n));
      step($sformatf("prefill%0d", n));
    end
    chk("prefill out_valid", 32'(ov[2]), 32'd1);
    drive(0, 0, 0, 0, '0);
    reset = 1'b0;
    #2;
    model_clear();
    check_all("async_reset");
    chk("async_reset in_flight", 32'(if4), 32'd0);
    @(posedge clk);
    #1;
    check_all("reset_held");
    reset = 1'b1;
    for (int n = 0; n < 5; n++) step($sformatf("post_reset%0d", n));

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 16) == 0, ($urandom % 4) == 0, $urandom % 2, $urandom % 2,
            AW'($urandom % 4096));
      step($sformatf("rnd%0d", n));
    end

`ifdef MAC_CTRL_PIPE_PARITY_EN
    drive(1, 0, 0, 0, '0);
    step("par_flush");
    for (int n = 0; n < 4; n++) begin
      drive(0, 0, 1, 0, AW'(12'h155));
      step($sformatf("par_fill%0d", n));
    end
    drive(0, 1, 0, 0, '0);
    force u_d4.g_stage[3].u_stage.q_addr = AW'(12'h154);
    @(posedge clk);
    #1;
    release u_d4.g_stage[3].u_stage.q_addr;
    chk("parity_err set", 32'(pe[2]), 32'd1);
    @(posedge clk);
    #1;
    chk("parity_err sticky", 32'(pe[2]), 32'd1);
    drive(1, 0, 0, 0, '0);
    @(posedge clk);
    model_edge();
    #1;
    chk("parity_err flush", 32'(pe[2]), 32'd0);
    drive(0, 0, 0, 0, '0);
    step("par_after");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
